// File: rtl/accel_cmd_bridge.sv
// Command bridge between the CPU accelerator bus and the NN accelerator core.
// Buffers bus writes in a small FIFO and decodes them into LOAD beat streams and RUN start/wait handshakes.
module accel_cmd_bridge #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accel_en,
  input  logic              bus_wr,
  input  logic [DATA_W-1:0] bus_data,
  output logic              accel_done,
  output logic [DATA_W-1:0] core_data,
  output logic              core_valid,
  input  logic              core_ready,
  output logic              core_start,
  output logic [3:0]        core_layer,
  input  logic              core_done,
  output logic [1:0]        err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_LOAD = 4'h1;
  localparam logic [3:0] OP_RUN  = 4'h2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN_START,
    S_RUN_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              empty, full, push, pop;

  logic [DATA_W-1:0] head;
  logic [3:0]        head_op, head_layer;
  logic [LEN_W-1:0]  head_len;

  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic              layer_load, illegal_op;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign push = bus_wr && (!full || pop);

  assign head       = mem[rd_ptr];
  assign head_op    = head[15:12];
  assign head_layer = head[11:8];
  assign head_len   = head[LEN_W-1:0];
  assign core_data  = head;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt     = state;
    remaining_nxt = remaining;
    pop           = 1'b0;
    core_valid    = 1'b0;
    core_start    = 1'b0;
    layer_load    = 1'b0;
    illegal_op    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (accel_en && !empty) begin
          pop = 1'b1;
          if (head_op == OP_LOAD) begin
            if (head_len != '0) begin
              state_nxt     = S_LOAD;
              remaining_nxt = head_len;
            end
          end else if (head_op == OP_RUN) begin
            state_nxt  = S_RUN_START;
            layer_load = 1'b1;
          end else begin
            illegal_op = 1'b1;
          end
        end
      end

      S_LOAD: begin
        core_valid = accel_en && !empty;
        if (core_valid && core_ready) begin
          pop           = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_nxt = S_IDLE;
        end
      end

      S_RUN_START: begin
        if (accel_en) begin
          core_start = 1'b1;
          state_nxt  = S_RUN_WAIT;
        end
      end

      S_RUN_WAIT: begin
        if (accel_en && core_done) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    unique case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // NOTE: the storage array has no reset; stale words are unreachable once the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      remaining  <= '0;
      core_layer <= 4'h0;
      err        <= 2'b00;
      accel_done <= 1'b1;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      count     <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (layer_load) core_layer <= head_layer;
      if (bus_wr && full && !pop) err[0] <= 1'b1;
      if (illegal_op) err[1] <= 1'b1;
      // Done only when nothing is running, nothing is queued and no new word is arriving.
      accel_done <= (state_nxt == S_IDLE) && (count_nxt == '0) && !bus_wr;
    end
  end

endmodule

// File: tb/tb_accel_cmd_bridge.sv
// Scoreboard bench for accel_cmd_bridge: directed command streams, queued expected beats/layers
// checked by a monitor process, plus direct checks of reset, timing, done and error flags.
module tb_accel_cmd_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        accel_en = 1'b1;
  logic        bus_wr = 1'b0;
  logic [15:0] bus_data = 16'h0000;
  logic        accel_done;
  logic [15:0] core_data;
  logic        core_valid;
  logic        core_ready = 1'b0;
  logic        core_start;
  logic [3:0]  core_layer;
  logic        core_done;
  logic [1:0]  err;

  logic man_done = 1'b0;
  logic auto_core_done = 1'b0;
  logic auto_done = 1'b0;
  assign core_done = man_done | auto_core_done;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  logic [15:0] exp_beats[$];
  logic [3:0]  exp_layers[$];

  accel_cmd_bridge #(.DATA_W(16), .FIFO_DEPTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .accel_en(accel_en), .bus_wr(bus_wr), .bus_data(bus_data),
    .accel_done(accel_done), .core_data(core_data), .core_valid(core_valid),
    .core_ready(core_ready), .core_start(core_start), .core_layer(core_layer),
    .core_done(core_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    bus_wr   = 1'b1;
    bus_data = w;
    tick();
    bus_wr   = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string name);
    int n = 0;
    while (!accel_done && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, accel_done, 1);
  endtask

  // Monitor: every accepted beat and every start pulse is matched against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (core_valid && core_ready) begin
        beats++;
        if (exp_beats.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_extra: got %0h expected none", core_data);
        end else begin
          check("beat_data", core_data, exp_beats.pop_front());
        end
      end
      if (core_start) begin
        if (exp_layers.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL start_extra: got layer %0h expected none", core_layer);
        end else begin
          check("start_layer", core_layer, exp_layers.pop_front());
        end
      end
    end
  end

  // Simple core model: acknowledge a RUN a few cycles after its start pulse.
  initial forever begin
    @(negedge clk);
    if (auto_done && core_start) begin
      repeat (3) @(posedge clk);
      #1 auto_core_done = 1'b1;
      @(posedge clk);
      #1 auto_core_done = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    // Reset
    repeat (2) tick();
    check("rst_done", accel_done, 1);
    check("rst_err", err, 0);
    check("rst_valid", core_valid, 0);
    check("rst_start", core_start, 0);
    rst_n = 1'b1;
    tick();

    // LOAD of three words with the core always ready
    core_ready = 1'b1;
    exp_beats.push_back(16'h0011);
    exp_beats.push_back(16'h0022);
    exp_beats.push_back(16'h0033);
    push(16'h1003);
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    wait_idle(50, "load_done");
    check("load_beats_left", exp_beats.size(), 0);

    // LOAD of four words under alternating backpressure
    core_ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 4; i++) exp_beats.push_back(16'h0031 + 16'(i));
    push(16'h1004);
    for (int i = 0; i < 4; i++) push(16'h0031 + 16'(i));
    for (int i = 0; i < 60 && !accel_done; i++) begin
      core_ready = ~core_ready;
      tick();
    end
    check("bp_done", accel_done, 1);
    check("bp_beat_count", beats - b0, 4);
    core_ready = 1'b1;

    // RUN layer 5: start at T+2, done held off until core_done
    exp_layers.push_back(4'h5);
    push(16'h2500);
    @(negedge clk);
    check("run_start_t1", core_start, 0);
    tick();
    @(negedge clk);
    check("run_start_t2", core_start, 1);
    check("run_layer", core_layer, 5);
    tick();
    check("run_start_once", core_start, 0);
    repeat (10) tick();
    check("run_done_wait", accel_done, 0);
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    check("run_done_rise", accel_done, 1);
    check("run_layer_hold", core_layer, 5);

    // Overflow with the FSM frozen, then drain
    accel_en = 1'b0;
    push(16'h1002);
    push(16'h00A1);
    push(16'h00A2);
    push(16'h2300);
    push(16'h1001);
    push(16'h00B1);
    push(16'h2400);
    push(16'h1000);
    check("ovf_err_before", err, 0);
    push(16'hDEAD);
    check("ovf_err", err, 1);
    check("ovf_valid_frozen", core_valid, 0);
    check("ovf_done", accel_done, 0);
    exp_beats.push_back(16'h00A1);
    exp_beats.push_back(16'h00A2);
    exp_beats.push_back(16'h00B1);
    exp_layers.push_back(4'h3);
    exp_layers.push_back(4'h4);
    auto_done = 1'b1;
    accel_en = 1'b1;
    wait_idle(300, "ovf_drain_done");
    check("ovf_beats_left", exp_beats.size(), 0);
    check("ovf_layers_left", exp_layers.size(), 0);

    // Illegal opcode followed by a valid RUN
    exp_layers.push_back(4'h1);
    push(16'hF000);
    push(16'h2100);
    wait_idle(100, "ill_done");
    check("ill_err", err, 3);
    check("ill_layer", core_layer, 1);

    // Reset in the middle of a LOAD discards the FIFO
    core_ready = 1'b0;
    push(16'h1005);
    push(16'h00C1);
    push(16'h00C2);
    tick();
    check("mid_load_valid", core_valid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_rst_done", accel_done, 1);
    check("mid_rst_valid", core_valid, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_layer", core_layer, 0);
    core_ready = 1'b1;
    exp_beats.push_back(16'h0077);
    push(16'h1001);
    push(16'h0077);
    wait_idle(50, "post_rst_done");

    repeat (3) tick();
    check("final_beats_left", exp_beats.size(), 0);
    check("final_layers_left", exp_layers.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
